ray_hit_scheduler: RTL and testbench

Sequencer in front of `ray_hit_pipeline`. It accepts one ray at a time, issues it against every scene object id on consecutive cycles, and collects the per-object results as they leave the pipeline. It reduces those results to the closest hit and hands that single result to the shading stage with a valid/ready handshake. All vectors are Q8.24 signed fixed point, packed {z,y,x} in 96 bits.

---
 rtl/ray_pkg.sv | 24 ++
 rtl/ray_hit_scheduler_if.sv | 56 +++++
 rtl/hit_min_reduce.sv | 80 ++++++++
 rtl/ray_hit_scheduler.sv | 127 ++++++++++++
 tb/tb_ray_hit_scheduler.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ray_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ray_pkg
// Brief    : Shared widths, constants and FSM encoding for the ray hit scheduler.
// Revision : 1.0
// ============================================================================
package ray_pkg;

  localparam int Q_W   = 32;  // Q8.24 scalar
  localparam int VEC_W = 96;  // packed {z,y,x}
  localparam int ID_W  = 3;   // object / material id
  localparam int CNT_W = 4;   // counts up to 8 objects inclusive

  localparam logic [Q_W-1:0] DIST_INF = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/ray_hit_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : ray_hit_scheduler_if
// Brief    : Ray input, pipeline issue/return and closest-hit result bundle.
// Revision : 1.0
// ============================================================================
interface ray_hit_scheduler_if;
  import ray_pkg::*;

  logic             ray_in_valid;
  logic             ray_in_ready;
  logic [VEC_W-1:0] ray_in_origin;
  logic [VEC_W-1:0] ray_in_direction;

  logic             pipe_new_data;
  logic [ID_W-1:0]  pipe_obj_id;
  logic [VEC_W-1:0] pipe_ray_origin;
  logic [VEC_W-1:0] pipe_ray_direction;
  logic             pipe_output_valid;
  logic             pipe_was_hit;
  logic [Q_W-1:0]   pipe_hit_dist;
  logic [VEC_W-1:0] pipe_hit_pos;
  logic [VEC_W-1:0] pipe_hit_normal;
  logic [ID_W-1:0]  pipe_hit_mat_id;

  logic             res_valid;
  logic             res_ready;
  logic             res_hit;
  logic [Q_W-1:0]   res_dist;
  logic [VEC_W-1:0] res_pos;
  logic [VEC_W-1:0] res_normal;
  logic [ID_W-1:0]  res_mat_id;
  logic [ID_W-1:0]  res_obj_id;

  modport master (
    input  ray_in_valid, ray_in_origin, ray_in_direction,
    output ray_in_ready,
    output pipe_new_data, pipe_obj_id, pipe_ray_origin, pipe_ray_direction,
    input  pipe_output_valid, pipe_was_hit, pipe_hit_dist, pipe_hit_pos,
    input  pipe_hit_normal, pipe_hit_mat_id,
    output res_valid, res_hit, res_dist, res_pos, res_normal, res_mat_id, res_obj_id,
    input  res_ready
  );

  modport slave (
    output ray_in_valid, ray_in_origin, ray_in_direction,
    input  ray_in_ready,
    input  pipe_new_data, pipe_obj_id, pipe_ray_origin, pipe_ray_direction,
    output pipe_output_valid, pipe_was_hit, pipe_hit_dist, pipe_hit_pos,
    output pipe_hit_normal, pipe_hit_mat_id,
    input  res_valid, res_hit, res_dist, res_pos, res_normal, res_mat_id, res_obj_id,
    output res_ready
  );

endinterface
`default_nettype wire

// File: rtl/hit_min_reduce.sv
`default_nettype none
// ============================================================================
// Module   : hit_min_reduce
// Brief    : Registered closest-hit accumulator; optional distance floor via
//            RAY_SCHED_MIN_DIST_EN.
// Revision : 1.0
// ============================================================================
module hit_min_reduce
  import ray_pkg::*;
#(
  parameter logic [Q_W-1:0] MIN_DIST = 32'h0001_0000
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear_i,
  input  wire logic             upd_valid_i,
  input  wire logic             cand_hit_i,
  input  wire logic [Q_W-1:0]   cand_dist_i,
  input  wire logic [VEC_W-1:0] cand_pos_i,
  input  wire logic [VEC_W-1:0] cand_normal_i,
  input  wire logic [ID_W-1:0]  cand_mat_i,
  input  wire logic [ID_W-1:0]  cand_obj_i,
  output logic                  best_hit_o,
  output logic [Q_W-1:0]        best_dist_o,
  output logic [VEC_W-1:0]      best_pos_o,
  output logic [VEC_W-1:0]      best_normal_o,
  output logic [ID_W-1:0]       best_mat_o,
  output logic [ID_W-1:0]       best_obj_o
);

`ifdef RAY_SCHED_MIN_DIST_EN
  localparam bit c_floor_en = 1'b1;
`else
  localparam bit c_floor_en = 1'b0;
`endif
  // With the floor disabled the most negative value makes the check vacuous.
  localparam logic [Q_W-1:0] c_floor = c_floor_en ? MIN_DIST : 32'h8000_0000;

  logic             best_hit_q;
  logic [Q_W-1:0]   best_dist_q;
  logic [VEC_W-1:0] best_pos_q;
  logic [VEC_W-1:0] best_normal_q;
  logic [ID_W-1:0]  best_mat_q;
  logic [ID_W-1:0]  best_obj_q;
  logic             take_d;

  // Strict less-than keeps the earlier (lower id) result on a tie.
  always_comb begin
    take_d = upd_valid_i && cand_hit_i
          && ($signed(cand_dist_i) >= $signed(c_floor))
          && ($signed(cand_dist_i) <  $signed(best_dist_q));
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      best_hit_q    <= 1'b0;
      best_dist_q   <= DIST_INF;
      best_pos_q    <= '0;
      best_normal_q <= '0;
      best_mat_q    <= '0;
      best_obj_q    <= '0;
    end else if (take_d) begin
      best_hit_q    <= 1'b1;
      best_dist_q   <= cand_dist_i;
      best_pos_q    <= cand_pos_i;
      best_normal_q <= cand_normal_i;
      best_mat_q    <= cand_mat_i;
      best_obj_q    <= cand_obj_i;
    end
  end

  assign best_hit_o    = best_hit_q;
  assign best_dist_o   = best_dist_q;
  assign best_pos_o    = best_pos_q;
  assign best_normal_o = best_normal_q;
  assign best_mat_o    = best_mat_q;
  assign best_obj_o    = best_obj_q;

endmodule
`default_nettype wire

// File: rtl/ray_hit_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ray_hit_scheduler
// Brief    : Issues one ray against NUM_OBJ objects, reduces returned results
//            to the closest hit. Option macro: RAY_SCHED_MIN_DIST_EN.
// Revision : 1.0
// ============================================================================
module ray_hit_scheduler
  import ray_pkg::*;
#(
  parameter int              NUM_OBJ  = 4,
  parameter logic [Q_W-1:0]  MIN_DIST = 32'h0001_0000
) (
  input  wire logic           clk,
  input  wire logic           rst,
  ray_hit_scheduler_if.master bus
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(NUM_OBJ);

  sched_state_e     state_q;
  logic [CNT_W-1:0] issue_cnt_q;
  logic [CNT_W-1:0] res_cnt_q;
  logic             pipe_new_data_q;
  logic [ID_W-1:0]  pipe_obj_id_q;
  logic [VEC_W-1:0] origin_q;
  logic [VEC_W-1:0] dir_q;
  logic             res_valid_q;

  logic accept_d;
  logic res_take_d;
  logic res_last_d;

  always_comb begin
    accept_d   = (state_q == ST_IDLE) && bus.ray_in_valid;
    res_take_d = ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) && bus.pipe_output_valid;
    res_last_d = res_take_d && ((res_cnt_q + CNT_W'(1)) == c_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      issue_cnt_q     <= '0;
      res_cnt_q       <= '0;
      pipe_new_data_q <= 1'b0;
      pipe_obj_id_q   <= '0;
      origin_q        <= '0;
      dir_q           <= '0;
      res_valid_q     <= 1'b0;
    end else begin
      if (res_take_d) begin
        res_cnt_q <= res_cnt_q + CNT_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            origin_q        <= bus.ray_in_origin;
            dir_q           <= bus.ray_in_direction;
            issue_cnt_q     <= CNT_W'(1);
            res_cnt_q       <= '0;
            pipe_new_data_q <= 1'b1;
            pipe_obj_id_q   <= '0;
            state_q         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Id 0 went out on the accept edge, so issue_cnt_q is the next id.
          if (res_last_d) begin
            pipe_new_data_q <= 1'b0;
            res_valid_q     <= 1'b1;
            state_q         <= ST_DONE;
          end else if (issue_cnt_q == c_last) begin
            pipe_new_data_q <= 1'b0;
            state_q         <= ST_DRAIN;
          end else begin
            pipe_obj_id_q <= issue_cnt_q[ID_W-1:0];
            issue_cnt_q   <= issue_cnt_q + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (res_last_d) begin
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Results return in issue order, so the result count is the object id.
  hit_min_reduce #(
    .MIN_DIST (MIN_DIST)
  ) u_reduce (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (accept_d),
    .upd_valid_i   (res_take_d),
    .cand_hit_i    (bus.pipe_was_hit),
    .cand_dist_i   (bus.pipe_hit_dist),
    .cand_pos_i    (bus.pipe_hit_pos),
    .cand_normal_i (bus.pipe_hit_normal),
    .cand_mat_i    (bus.pipe_hit_mat_id),
    .cand_obj_i    (res_cnt_q[ID_W-1:0]),
    .best_hit_o    (bus.res_hit),
    .best_dist_o   (bus.res_dist),
    .best_pos_o    (bus.res_pos),
    .best_normal_o (bus.res_normal),
    .best_mat_o    (bus.res_mat_id),
    .best_obj_o    (bus.res_obj_id)
  );

  assign bus.ray_in_ready       = (state_q == ST_IDLE);
  assign bus.pipe_new_data      = pipe_new_data_q;
  assign bus.pipe_obj_id        = pipe_obj_id_q;
  assign bus.pipe_ray_origin    = origin_q;
  assign bus.pipe_ray_direction = dir_q;
  assign bus.res_valid          = res_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ray_hit_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ray_hit_scheduler
// Brief    : Directed bench for ray_hit_scheduler with a latency-10 pipeline model.
// Revision : 1.0
// ============================================================================
module tb_ray_hit_scheduler;
  import ray_pkg::*;

  localparam int NOBJ = 4;
  localparam int LAT  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  ray_hit_scheduler_if bus ();

  ray_hit_scheduler #(
    .NUM_OBJ  (NOBJ),
    .MIN_DIST (32'h0001_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural pipeline: per-object results come from a table.
  logic           t_hit  [8];
  logic [31:0]    t_dist [8];
  logic           v_sr   [LAT+1];
  logic [2:0]     id_sr  [LAT+1];
  logic [2:0]     out_id;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= LAT; i++) begin
        v_sr[i]  <= 1'b0;
        id_sr[i] <= 3'd0;
      end
    end else begin
      v_sr[0]  <= bus.pipe_new_data;
      id_sr[0] <= bus.pipe_obj_id;
      for (int i = 1; i <= LAT; i++) begin
        v_sr[i]  <= v_sr[i-1];
        id_sr[i] <= id_sr[i-1];
      end
    end
  end

  assign out_id                = id_sr[LAT];
  assign bus.pipe_output_valid = v_sr[LAT];
  assign bus.pipe_was_hit      = t_hit[out_id];
  assign bus.pipe_hit_dist     = t_dist[out_id];
  assign bus.pipe_hit_pos      = {3{32'h10 + 32'(out_id)}};
  assign bus.pipe_hit_normal   = {3{32'h20 + 32'(out_id)}};
  assign bus.pipe_hit_mat_id   = out_id + 3'd1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_tbl(input logic [3:0] hits, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
    for (int i = 0; i < 8; i++) begin
      t_hit[i]  = 1'b0;
      t_dist[i] = 32'h0;
    end
    for (int i = 0; i < 4; i++) t_hit[i] = hits[i];
    t_dist[0] = d0; t_dist[1] = d1; t_dist[2] = d2; t_dist[3] = d3;
  endtask

  // Entered #1 after the accept edge; lat counts edges until res_valid shows.
  task automatic wait_res(output int lat, output int nd);
    lat = 0;
    nd  = 0;
    while (!bus.res_valid && lat < 60) begin
      if (bus.pipe_new_data) nd++;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.res_valid) chk("res_valid_timeout", bus.res_valid, 1'b1);
  endtask

  task automatic run_ray(input logic [95:0] org, output int lat, output int nd);
    bus.ray_in_origin    = org;
    bus.ray_in_direction = {32'h0100_0000, 64'h0};
    bus.ray_in_valid     = 1'b1;
    @(posedge clk); #1;
    bus.ray_in_valid = 1'b0;
    wait_res(lat, nd);
  endtask

  task automatic pop();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk("ready_after_pop", bus.ray_in_ready, 1'b1);
  endtask

`ifdef RAY_SCHED_MIN_DIST_EN
  localparam logic [2:0]  EXP_MD_OBJ  = 3'd1;
  localparam logic [31:0] EXP_MD_DIST = 32'h0100_0000;
`else
  localparam logic [2:0]  EXP_MD_OBJ  = 3'd0;
  localparam logic [31:0] EXP_MD_DIST = 32'h0000_8000;
`endif

  int lat;
  int nd;

  initial begin
    bus.ray_in_valid     = 1'b0;
    bus.ray_in_origin    = '0;
    bus.ray_in_direction = '0;
    bus.res_ready        = 1'b0;
    set_tbl(4'b0000, 0, 0, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",     bus.ray_in_ready, 1'b1);
    chk("rst_new_data",  bus.pipe_new_data, 1'b0);
    chk("rst_obj_id",    bus.pipe_obj_id, 3'd0);
    chk("rst_origin",    bus.pipe_ray_origin, 96'h0);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_hit",   bus.res_hit, 1'b0);
    chk("rst_res_dist",  bus.res_dist, 32'h7FFF_FFFF);
    chk("rst_res_obj",   bus.res_obj_id, 3'd0);
    chk("rst_res_pos",   bus.res_pos, 96'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Hits on id 1 (3.0) and id 2 (1.5)
    set_tbl(4'b0110, 32'h0, 32'h0300_0000, 32'h0180_0000, 32'h0);
    run_ray({32'h1, 32'h2, 32'h3}, lat, nd);
    chk("t1_latency",  lat, 15);
    chk("t1_new_data", nd, 4);
    chk("t1_hit",      bus.res_hit, 1'b1);
    chk("t1_dist",     bus.res_dist, 32'h0180_0000);
    chk("t1_obj",      bus.res_obj_id, 3'd2);
    chk("t1_mat",      bus.res_mat_id, 3'd3);
    chk("t1_pos",      bus.res_pos, {3{32'h12}});
    chk("t1_normal",   bus.res_normal, {3{32'h22}});
    chk("t1_origin",   bus.pipe_ray_origin, {32'h1, 32'h2, 32'h3});
    chk("t1_ready",    bus.ray_in_ready, 1'b0);
    pop();

    // All misses
    set_tbl(4'b0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000);
    run_ray({3{32'h5}}, lat, nd);
    chk("t2_hit",  bus.res_hit, 1'b0);
    chk("t2_dist", bus.res_dist, 32'h7FFF_FFFF);
    chk("t2_obj",  bus.res_obj_id, 3'd0);
    chk("t2_mat",  bus.res_mat_id, 3'd0);
    chk("t2_pos",  bus.res_pos, 96'h0);
    pop();

    // Tie at 2.0 between ids 0 and 3; id 1 farther
    set_tbl(4'b1011, 32'h0200_0000, 32'h0280_0000, 32'h0, 32'h0200_0000);
    run_ray({3{32'h6}}, lat, nd);
    chk("t3_hit",    bus.res_hit, 1'b1);
    chk("t3_dist",   bus.res_dist, 32'h0200_0000);
    chk("t3_obj",    bus.res_obj_id, 3'd0);
    chk("t3_mat",    bus.res_mat_id, 3'd1);
    chk("t3_normal", bus.res_normal, {3{32'h20}});

    // Backpressure in DONE with the next ray already offered
    set_tbl(4'b0010, 32'h0, 32'h0040_0000, 32'h0, 32'h0);
    bus.ray_in_origin = {3{32'h7}};
    bus.ray_in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", bus.res_valid, 1'b1);
      chk("t4_hold_obj",   bus.res_obj_id, 3'd0);
      chk("t4_hold_dist",  bus.res_dist, 32'h0200_0000);
      chk("t4_hold_ready", bus.ray_in_ready, 1'b0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk("t4_idle_ready", bus.ray_in_ready, 1'b1);
    chk("t4_idle_valid", bus.res_valid, 1'b0);
    @(posedge clk); #1;
    bus.ray_in_valid = 1'b0;
    chk("t4_accept_ready", bus.ray_in_ready, 1'b0);
    chk("t4_accept_nd",    bus.pipe_new_data, 1'b1);
    chk("t4_accept_org",   bus.pipe_ray_origin, {3{32'h7}});
    wait_res(lat, nd);
    chk("t4_latency", lat, 15);
    chk("t4_obj",     bus.res_obj_id, 3'd1);
    chk("t4_dist",    bus.res_dist, 32'h0040_0000);
    pop();

    // Reset during the second ISSUE cycle
    set_tbl(4'b0110, 32'h0, 32'h0300_0000, 32'h0180_0000, 32'h0);
    bus.ray_in_valid = 1'b1;
    @(posedge clk); #1;
    bus.ray_in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_ready",     bus.ray_in_ready, 1'b1);
    chk("t5_new_data",  bus.pipe_new_data, 1'b0);
    chk("t5_res_valid", bus.res_valid, 1'b0);
    chk("t5_res_dist",  bus.res_dist, 32'h7FFF_FFFF);
    run_ray({3{32'h8}}, lat, nd);
    chk("t5_latency", lat, 15);
    chk("t5_obj",     bus.res_obj_id, 3'd2);
    chk("t5_dist",    bus.res_dist, 32'h0180_0000);
    pop();

    // Near-zero hit on id 0 versus 1.0 on id 1
    set_tbl(4'b0011, 32'h0000_8000, 32'h0100_0000, 32'h0, 32'h0);
    run_ray({3{32'h9}}, lat, nd);
    chk("t6_hit",  bus.res_hit, 1'b1);
    chk("t6_obj",  bus.res_obj_id, EXP_MD_OBJ);
    chk("t6_dist", bus.res_dist, EXP_MD_DIST);
    pop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
